uart_tx_fifo: RTL and testbench

- Buffered, parametrised UART transmitter. Successor to the single-word transmitter.
- Accepts words through a valid/ready stream into an internal FIFO and serialises them LSB-first onto one RS232-style line.
- Data width, parity mode (none/even/odd), stop-bit count and buffer depth are configurable.
- Frames stream back-to-back with no idle gap while the FIFO holds data; feeds the host link of the sigma-delta ADC readout.

---
 rtl/uart_tx_fifo.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready write port into a power-of-two FIFO, frames
// serialised LSB-first with optional parity and 1..2 stop bits, back-to-back while data waits.
module uart_tx_fifo #(
  parameter int unsigned C_CLK_FRQ         = 100_000_000,
  parameter int unsigned C_UART_RATE       = 1_000_000,
  parameter int unsigned C_UART_DATA_WIDTH = 8,
  parameter int unsigned C_UART_PARITY     = 0,
  parameter int unsigned C_UART_STOP       = 1,
  parameter int unsigned C_FIFO_DEPTH      = 16
) (
  input  logic                               clk,
  input  logic                               rstb,
  input  logic [C_UART_DATA_WIDTH-1:0]       s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic [$clog2(C_FIFO_DEPTH):0]      level,
  output logic                               busy,
  output logic                               done,
  output logic                               tx
);

  localparam int unsigned C_PERIOD = C_CLK_FRQ / C_UART_RATE;
  localparam int unsigned CntW     = (C_PERIOD > 1) ? $clog2(C_PERIOD) : 1;
  localparam int unsigned AddrW    = $clog2(C_FIFO_DEPTH);
  localparam int unsigned LvlW     = AddrW + 1;
  localparam int unsigned BitW     = 4;
  localparam bit          ParEn    = (C_UART_PARITY != 0);
  localparam bit          ParOdd   = (C_UART_PARITY == 2);

  if (C_PERIOD < 2 || C_UART_DATA_WIDTH < 5 || C_UART_DATA_WIDTH > 9 ||
      C_UART_PARITY > 2 || C_UART_STOP < 1 || C_UART_STOP > 2 || C_FIFO_DEPTH < 2 ||
      (C_FIFO_DEPTH & (C_FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $fatal(1, "uart_tx_fifo: illegal parameter value");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // FIFO storage and bookkeeping
  logic [C_UART_DATA_WIDTH-1:0] mem_q [C_FIFO_DEPTH];
  logic [AddrW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]              level_q, level_d;
  logic                         push, pop, full;
  logic [C_UART_DATA_WIDTH-1:0] head;
  logic                         head_par;

  // Transmitter state
  state_e                       state_q;
  logic [CntW-1:0]              cnt_q;
  logic [BitW-1:0]              bit_q;
  logic [C_UART_DATA_WIDTH-1:0] shift_q;
  logic                         par_q;
  logic                         tx_q, done_q, busy_q;
  logic                         bit_end, last_data, last_stop;

  assign full     = (level_q == LvlW'(C_FIFO_DEPTH));
  assign s_ready  = ~full;
  assign push     = s_valid & s_ready;
  assign head     = mem_q[rd_ptr_q];
  assign head_par = (^head) ^ ParOdd;

  assign bit_end   = (cnt_q == CntW'(C_PERIOD - 1));
  assign last_data = (bit_q == BitW'(C_UART_DATA_WIDTH - 1));
  assign last_stop = (bit_q == BitW'(C_UART_STOP - 1));

  // A pop happens from IDLE, or on the final clock of the last stop bit so the next
  // start bit follows without an idle gap.
  assign pop = (level_q != '0) &&
               ((state_q == StIdle) || (state_q == StStop && bit_end && last_stop));

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      level_q <= level_d;
    end
  end

  // tx, done and busy are registered from the current state, so the line trails the
  // state register by one clock uniformly and every bit keeps its full period.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state_q != StIdle) || (level_q != '0);
      cnt_q  <= (state_q == StIdle || bit_end) ? '0 : cnt_q + CntW'(1);
      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= head;
            par_q   <= head_par;
            bit_q   <= '0;
            state_q <= StStart;
          end
        end
        StStart: begin
          tx_q <= 1'b0;
          if (bit_end) begin
            bit_q   <= '0;
            state_q <= StData;
          end
        end
        StData: begin
          tx_q <= shift_q[0];
          if (bit_end) begin
            shift_q <= shift_q >> 1;
            if (last_data) begin
              bit_q   <= '0;
              state_q <= ParEn ? StParity : StStop;
            end else begin
              bit_q <= bit_q + BitW'(1);
            end
          end
        end
        StParity: begin
          tx_q <= par_q;
          if (bit_end) begin
            bit_q   <= '0;
            state_q <= StStop;
          end
        end
        StStop: begin
          tx_q <= 1'b1;
          if (bit_end) begin
            if (last_stop) begin
              done_q <= 1'b1;
              bit_q  <= '0;
              if (pop) begin
                shift_q <= head;
                par_q   <= head_par;
                state_q <= StStart;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              bit_q <= bit_q + BitW'(1);
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          bit_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign level = level_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations, directed writes, frames checked by
// per-DUT monitors against a queue of hand-computed frame bit patterns.
module tb_uart_tx_fifo;

  localparam int P = 10;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] s_data_a, s_data_b;
  logic [6:0] s_data_c;
  logic [2:0] s_valid_v;
  wire  [2:0] s_ready_v, busy_v, done_v, tx_v;
  wire  [2:0] level_a, level_b, level_c;

  // a: 8 bit, even parity, 1 stop. b: 8 bit, odd parity, 1 stop. c: 7 bit, none, 2 stop.
  uart_tx_fifo #(.C_CLK_FRQ(100_000_000), .C_UART_RATE(10_000_000), .C_UART_DATA_WIDTH(8),
                 .C_UART_PARITY(1), .C_UART_STOP(1), .C_FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rstb(rstb), .s_data(s_data_a), .s_valid(s_valid_v[0]), .s_ready(s_ready_v[0]),
    .level(level_a), .busy(busy_v[0]), .done(done_v[0]), .tx(tx_v[0]));

  uart_tx_fifo #(.C_CLK_FRQ(100_000_000), .C_UART_RATE(10_000_000), .C_UART_DATA_WIDTH(8),
                 .C_UART_PARITY(2), .C_UART_STOP(1), .C_FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rstb(rstb), .s_data(s_data_b), .s_valid(s_valid_v[1]), .s_ready(s_ready_v[1]),
    .level(level_b), .busy(busy_v[1]), .done(done_v[1]), .tx(tx_v[1]));

  uart_tx_fifo #(.C_CLK_FRQ(100_000_000), .C_UART_RATE(10_000_000), .C_UART_DATA_WIDTH(7),
                 .C_UART_PARITY(0), .C_UART_STOP(2), .C_FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rstb(rstb), .s_data(s_data_c), .s_valid(s_valid_v[2]), .s_ready(s_ready_v[2]),
    .level(level_c), .busy(busy_v[2]), .done(done_v[2]), .tx(tx_v[2]));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Expected frames, bit i = i-th bit on the line (start bit at index 0).
  logic [15:0] exp_a[$], exp_b[$], exp_c[$];
  int          start_a[$];

  function automatic void exp_push(input int id, input logic [15:0] fr);
    if (id == 0) exp_a.push_back(fr);
    else if (id == 1) exp_b.push_back(fr);
    else exp_c.push_back(fr);
  endfunction

  function automatic int exp_size(input int id);
    if (id == 0) return exp_a.size();
    if (id == 1) return exp_b.size();
    return exp_c.size();
  endfunction

  function automatic logic [15:0] exp_pop(input int id);
    if (id == 0) return exp_a.pop_front();
    if (id == 1) return exp_b.pop_front();
    return exp_c.pop_front();
  endfunction

  function automatic logic [2:0] level_of(input int id);
    if (id == 0) return level_a;
    if (id == 1) return level_b;
    return level_c;
  endfunction

  task automatic monitor(input int id, input int nbits);
    logic [15:0] fr;
    int bad_tx, bad_done;
    bit aborted;
    forever begin
      @(negedge clk);
      if (rstb && tx_v[id] === 1'b0) begin
        if (id == 0) start_a.push_back(cyc);
        if (exp_size(id) == 0) begin
          check($sformatf("frame%0d_expected", id), 0, 1);
          fr = '1;
        end else begin
          fr = exp_pop(id);
        end
        bad_tx = 0;
        bad_done = 0;
        aborted = 1'b0;
        for (int i = 0; i < nbits * P; i++) begin
          if (i > 0) @(negedge clk);
          if (!rstb) begin
            aborted = 1'b1;
            break;
          end
          if (tx_v[id] !== fr[i/P]) bad_tx++;
          if (done_v[id] !== (i == nbits * P - 1)) bad_done++;
        end
        if (!aborted) begin
          check($sformatf("frame%0d_tx_bad_cycles", id), bad_tx, 0);
          check($sformatf("frame%0d_done_bad_cycles", id), bad_done, 0);
        end
      end
    end
  endtask

  task automatic push(input int id, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    if (id == 0) s_data_a = d;
    else if (id == 1) s_data_b = d;
    else s_data_c = d[6:0];
    s_valid_v[id] = 1'b1;
    for (int t = 0; t < 2000 && !ok; t++) begin
      if (t > 0) @(negedge clk);
      ok = s_ready_v[id];
      @(posedge clk);
    end
    #1 s_valid_v[id] = 1'b0;
    if (!ok) check($sformatf("push%0d_accepted", id), 0, 1);
  endtask

  task automatic wait_idle(input int id, input int lim);
    bit hit;
    hit = 1'b0;
    repeat (3) @(negedge clk);
    for (int t = 0; t < lim && !hit; t++) begin
      @(negedge clk);
      hit = (busy_v[id] === 1'b0) && (level_of(id) === 3'd0);
    end
    check($sformatf("idle%0d_reached", id), hit, 1);
  endtask

  initial begin
    #(10 * 50_000);
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bit hit;
    int seq, nchg, bad_rdy, bad;
    logic [2:0] prev;
    s_valid_v = '0;
    s_data_a = '0;
    s_data_b = '0;
    s_data_c = '0;
    fork
      monitor(0, 11);
      monitor(1, 11);
      monitor(2, 10);
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_a", tx_v[0], 1);
    check("rst_busy_a", busy_v[0], 0);
    check("rst_done_a", done_v[0], 0);
    check("rst_level_a", level_a, 0);
    check("rst_ready_a", s_ready_v[0], 1);
    check("rst_tx_bc", tx_v[2:1], 3);
    @(negedge clk);
    rstb = 1'b1;
    repeat (3) @(negedge clk);

    // 0xA5, even parity 0; latency, done and busy timing
    exp_push(0, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0});
    push(0, 8'hA5);
    @(negedge clk);
    check("lat_tx_n0", tx_v[0], 1);
    check("lat_busy_n0", busy_v[0], 0);
    check("lat_level_n0", level_a, 1);
    @(negedge clk);
    check("lat_tx_n1", tx_v[0], 1);
    check("lat_busy_n1", busy_v[0], 1);
    check("lat_level_n1", level_a, 0);
    @(negedge clk);
    check("lat_tx_n2", tx_v[0], 0);
    hit = 1'b0;
    for (int t = 0; t < 200 && !hit; t++) begin
      @(negedge clk);
      hit = (done_v[0] === 1'b1);
    end
    check("done_seen", hit, 1);
    check("busy_at_done", busy_v[0], 1);
    @(negedge clk);
    check("busy_after_done", busy_v[0], 0);
    check("done_one_cycle", done_v[0], 0);

    // Odd parity on b (0xA5 -> 1); 7-bit, 2 stop bits on c
    exp_push(1, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0});
    push(1, 8'hA5);
    exp_push(2, {6'b0, 2'b11, 7'h7F, 1'b0});
    exp_push(2, {6'b0, 2'b11, 7'h2A, 1'b0});
    push(2, 8'h7F);
    push(2, 8'h2A);

    // Back-to-back frames on a: start bits exactly one frame apart
    start_a.delete();
    exp_push(0, {5'b0, 1'b1, 1'b1, 8'h01, 1'b0});
    exp_push(0, {5'b0, 1'b1, 1'b1, 8'h80, 1'b0});
    push(0, 8'h01);
    push(0, 8'h80);
    wait_idle(0, 400);
    check("b2b_frames", start_a.size(), 2);
    if (start_a.size() == 2) check("b2b_spacing", start_a[1] - start_a[0], 110);
    wait_idle(1, 500);
    wait_idle(2, 500);

    // Backpressure on a with a frame in flight: level 1,2,3,4,3(pop),4
    exp_push(0, {5'b0, 1'b1, 1'b1, 8'h13, 1'b0});
    exp_push(0, {5'b0, 1'b1, 1'b0, 8'h22, 1'b0});
    exp_push(0, {5'b0, 1'b1, 1'b1, 8'h37, 1'b0});
    exp_push(0, {5'b0, 1'b1, 1'b0, 8'h44, 1'b0});
    exp_push(0, {5'b0, 1'b1, 1'b1, 8'h5B, 1'b0});
    exp_push(0, {5'b0, 1'b1, 1'b0, 8'h6C, 1'b0});
    push(0, 8'h13);
    repeat (3) @(negedge clk);
    seq = 0;
    nchg = 0;
    bad_rdy = 0;
    prev = level_a;
    fork
      begin
        push(0, 8'h22);
        push(0, 8'h37);
        push(0, 8'h44);
        push(0, 8'h5B);
        push(0, 8'h6C);
      end
      begin
        for (int i = 0; i < 140; i++) begin
          @(negedge clk);
          if (s_ready_v[0] !== (level_a != 3'd4)) bad_rdy++;
          if (level_a !== prev) begin
            if (nchg < 8) seq = seq * 10 + int'(level_a);
            nchg++;
            prev = level_a;
          end
        end
      end
    join
    check("level_sequence", seq, 123434);
    check("ready_vs_full_bad_cycles", bad_rdy, 0);
    wait_idle(0, 1000);

    // Reset at clock 45 of a frame with two words queued
    exp_push(0, {5'b0, 1'b1, 1'b0, 8'h0F, 1'b0});
    exp_push(0, {5'b0, 1'b1, 1'b0, 8'hF0, 1'b0});
    exp_push(0, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0});
    push(0, 8'h0F);
    push(0, 8'hF0);
    push(0, 8'h3C);
    hit = 1'b0;
    for (int t = 0; t < 50 && !hit; t++) begin
      @(negedge clk);
      hit = (tx_v[0] === 1'b0);
    end
    check("rst_frame_started", hit, 1);
    repeat (44) @(negedge clk);
    check("rst_level_before", level_a, 2);
    #2 rstb = 1'b0;
    #1;
    check("rst_async_tx", tx_v[0], 1);
    check("rst_async_level", level_a, 0);
    check("rst_async_busy", busy_v[0], 0);
    check("rst_async_ready", s_ready_v[0], 1);
    exp_a.delete();
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx_v !== 3'b111) bad++;
    end
    check("post_rst_tx_idle_bad_cycles", bad, 0);
    check("post_rst_busy", busy_v, 0);
    check("final_levels", {level_a, level_b, level_c}, 0);
    check("scoreboard_left", exp_a.size() + exp_b.size() + exp_c.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
